// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - control-word type and data-memory req/ack bus for the memory stage
//
// rvga_pkg::rvga_cword : pipeline control word carried from execute through writeback.
// mem_access_if        : data-memory bus.
//   req   master->slave  request valid, held until ack
//   we    master->slave  1 = store
//   addr  master->slave  word-aligned byte address
//   wdata master->slave  lane-replicated store data
//   be    master->slave  byte enables (stores only)
//   ack   slave->master  access complete, rdata valid this cycle
//   rdata slave->master  load word

package rvga_pkg;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic [31:0] rs2_data;
    logic [31:0] rd_data;
  } rvga_cword;

endpackage

interface mem_access_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - rvga memory stage: loads/stores over req/ack, load alignment, upstream stall
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   stall_in       downstream hold; freezes mem_wb_cword and holds DONE
//   stall_out      upstream hold: stall_in or a memory access in flight
//   ex_mem_cword   control word from execute (rd_data = byte address for memory ops)
//   mem_wb_cword   control word to writeback (rd_data = load result for loads)
//   dmem           data-memory bus master
//   misalign       one-cycle pulse when a misaligned access is dropped

module mem_access
  import rvga_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_in,
  output logic         stall_out,
  input  rvga_cword    ex_mem_cword,
  output rvga_cword    mem_wb_cword,
  mem_access_if.master dmem,
  output logic         misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  rvga_cword         op_q, op_d;
  rvga_cword         mwb_q, mwb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              misalign_q, misalign_d;

  // Decode of the incoming word; funct3 values outside B/H/BU/HU fall into word size.
  logic [1:0]  in_a;
  logic        in_byte, in_half, in_word, in_mem, in_mis;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;

  assign in_a    = ex_mem_cword.rd_data[1:0];
  assign in_byte = (ex_mem_cword.funct3[1:0] == 2'b00);
  assign in_half = (ex_mem_cword.funct3[1:0] == 2'b01);
  assign in_word = !in_byte && !in_half;
  assign in_mem  = ex_mem_cword.mem_read || ex_mem_cword.mem_write;
  assign in_mis  = in_mem && ((in_half && in_a[0]) || (in_word && (in_a != 2'b00)));

  always_comb begin
    st_wdata = ex_mem_cword.rs2_data;
    st_be    = 4'b1111;
    if (in_byte) begin
      st_wdata = {4{ex_mem_cword.rs2_data[7:0]}};
      st_be    = 4'b0001 << in_a;
    end else if (in_half) begin
      st_wdata = {2{ex_mem_cword.rs2_data[15:0]}};
      st_be    = 4'b0011 << in_a;
    end
  end

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0] s;
    logic [31:0] r;
    s = w >> {a, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'b0, s[7:0]};
      3'b101:  r = {16'b0, s[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mwb_d      = mwb_q;
    rdata_d    = rdata_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    misalign_d = 1'b0;
    stall_out  = stall_in;

    case (state_q)
      IDLE: begin
        if (in_mem && !in_mis) begin
          // Access is launched regardless of stall_in; only the writeback update waits.
          stall_out = 1'b1;
          state_d   = BUSY;
          op_d      = ex_mem_cword;
          req_d     = 1'b1;
          we_d      = ex_mem_cword.mem_write;
          addr_d    = {ex_mem_cword.rd_data[ADDR_W-1:2], 2'b00};
          wdata_d   = st_wdata;
          be_d      = ex_mem_cword.mem_write ? st_be : 4'b0000;
        end else if (!stall_in) begin
          mwb_d = ex_mem_cword;
          if (in_mis) begin
            mwb_d.reg_write = 1'b0;
            misalign_d      = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        if (dmem.ack) begin
          rdata_d = dmem.rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Leaving DONE always consumes the word, so the access is never reissued.
        if (!stall_in) begin
          mwb_d = op_q;
          if (op_q.mem_read && !op_q.mem_write) begin
            mwb_d.rd_data = load_align(op_q.funct3, op_q.rd_data[1:0], rdata_q);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      mwb_q      <= '0;
      rdata_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mwb_q      <= mwb_d;
      rdata_q    <= rdata_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      misalign_q <= misalign_d;
    end
  end

  assign mem_wb_cword = mwb_q;
  assign dmem.req     = req_q;
  assign dmem.we      = we_q;
  assign dmem.addr    = addr_q;
  assign dmem.wdata   = wdata_q;
  assign dmem.be      = be_q;
  assign misalign     = misalign_q;

endmodule
